// File: rtl/afifo_rd_outbuf.sv
// Read-side output stage of the async FIFO: a 2-entry main/skid buffer that turns the
// FIFO head (vld/pop) into a fully registered valid/ready stream without exposing out_rdy to pop.
module afifo_rd_outbuf #(
  parameter int DW = 38
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          fifo_vld,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_pop,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  input  logic          out_rdy,
  output logic [1:0]    lvl
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ONE     = 2'd1,
    FULL    = 2'd2,
    ILLEGAL = 2'd3
  } st_t;

  st_t           st;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          drain;

  // Handshake: a word moves on out_* in any cycle where out_vld & out_rdy; out_vld and
  // out_data hold until that happens. The head moves on fifo_* when fifo_pop is high.
  assign out_vld  = (st == ONE) || (st == FULL);
  assign out_data = main_q;
  assign drain    = out_vld & out_rdy;
  assign lvl      = st;

  // Pop depends only on the state flop and fifo_vld, never on the consumer.
  assign fifo_pop = fifo_vld & ~rst & (st != FULL);

  always_ff @(posedge rclk) begin
    if (rst) begin
      st <= EMPTY;
    end else begin
      case (st)
        ONE: begin
          if (fifo_pop && drain) begin
            main_q <= fifo_data;
          end else if (fifo_pop) begin
            skid_q <= fifo_data;
            st     <= FULL;
          end else if (drain) begin
            st <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q <= skid_q;
            st     <= ONE;
          end
        end
        // EMPTY, and the unreachable encoding treated as EMPTY.
        default: begin
          if (fifo_pop) begin
            main_q <= fifo_data;
            st     <= ONE;
          end else begin
            st <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/afifo_rd_outbuf.md
Name: afifo_rd_outbuf

Overview:
- Read-side output stage of the async FIFO, directly downstream of the read-pointer logic and the dual-port RAM.
- Turns the FIFO's vld/pop head interface into a fully registered valid/ready stream for the read-domain consumer.
- Uses a 2-entry main/skid buffer, so consumer backpressure (out_rdy) never reaches pop, rd_addr or the RAM address path.
- Sustains 1 word/cycle.

Parameters:
- DW, 38, data width in bits; matches the FIFO RAM word width.

Ports:
- rclk, input, 1, read-domain clock.
- rst, input, 1, synchronous active-high reset.
- fifo_vld, input, 1, FIFO head valid; this is the read logic's vld, equal to ~empty.
- fifo_data, input, DW, RAM read data for the current head. It is valid in any cycle where fifo_vld=1, because the RAM is addressed with the next read pointer.
- fifo_pop, output, 1, pop to the read logic; consumes the head this cycle.
- out_vld, output, 1, output word valid.
- out_data, output, DW, output word.
- out_rdy, input, 1, consumer ready.
- lvl, output, 2, buffer occupancy, 0..2.

Behaviour:
- Interface: one clock, rclk. Reset rst is synchronous and active-high.
- State register st encodes occupancy: EMPTY=0, ONE=1, FULL=2. lvl = st.
- Datapath registers:
  - main: always drives out_data.
  - skid: overflow entry.
- Combinational terms:
  - drain = out_vld & out_rdy.
  - fifo_pop = fifo_vld & (st != FULL).
  - fifo_pop depends only on registered state and fifo_vld, never on out_rdy.
- out_vld = (st != EMPTY), registered-equivalent (decoded straight from the flop).
- Transitions, evaluated per rclk edge:
  - EMPTY: pop -> ONE, main<=fifo_data; else stay.
  - ONE: pop & drain -> ONE, main<=fifo_data.
  - ONE: pop & !drain -> FULL, skid<=fifo_data.
  - ONE: !pop & drain -> EMPTY.
  - ONE: neither -> stay.
  - FULL: pop is impossible. drain -> ONE, main<=skid; else stay, main and skid held.
- Latency: a word popped in cycle N appears on out_data with out_vld=1 in cycle N+1, provided st was EMPTY, or st was ONE with drain.
- Throughput: with fifo_vld=1 and out_rdy=1 held, there is one transfer per cycle, st stays ONE, and there are no bubbles.
- Ordering: strict FIFO order; skid data is always older than any word popped afterwards.
- out_data is stable while out_vld=1 and out_rdy=0. The data register is not rewritten while stalled.
- out_vld never deasserts without a drain (AXI-style valid hold).
- fifo_data is ignored whenever fifo_pop=0.
- Reset:
  - st=EMPTY, so out_vld=0, fifo_pop=0 during rst, and lvl=0.
  - main and skid need no reset; out_data after reset is don't-care until the first out_vld.
- Reset mid-operation: buffered words are discarded. The FIFO read logic is reset in the same cycle, so no pop is issued while rst=1.
- Illegal/unreachable: st=3 decodes as EMPTY on the next edge; the bench checks this is never entered.

Test Plan:
- Reset, then fifo_vld=0 for 5 cycles -> out_vld=0, fifo_pop=0, lvl=0 throughout.
- Feed 0x01..0x08 back-to-back with out_rdy=1 -> fifo_pop high for 8 consecutive cycles. out_data shows 0x01..0x08 on consecutive cycles starting 1 cycle after the first pop. lvl=1 steady, then 0.
- Feed 0xA0,0xA1,0xA2 with out_rdy=0 -> 2 pops then fifo_pop=0, lvl=2, out_data=0xA0 held. Raise out_rdy -> outputs 0xA0,0xA1,0xA2 in order, third pop occurs the cycle lvl returns to 1.
- Random fifo_vld (50%) and out_rdy (30%), 2000 words -> scoreboard exact order, no loss or duplication. out_data stable whenever out_vld & !out_rdy. lvl never exceeds 2.
- Assert rst for one cycle while lvl=2 -> next cycle lvl=0, out_vld=0. Subsequent word 0x5A is delivered as the first output.
- out_rdy toggling every cycle with continuous fifo_vld -> no bubble while lvl>0. fifo_pop never asserted in a cycle where lvl=2.
